// File: rtl/perf_counter_mmio_pkg.sv
// Shared constants for the performance-counter MMIO window: counter selects
// and the load/store addresses decoded by the memory stage.
package perf_counter_mmio_pkg;

    // Counter select encoding, shared with the memory-stage decoder
    typedef enum logic [1:0] {
        CSEL_CYCLE   = 2'd0,
        CSEL_INST    = 2'd1,
        CSEL_BRANCH  = 2'd2,
        CSEL_CORRECT = 2'd3
    } csel_e;

    localparam int unsigned NUM_CNT = 4;

    // MMIO addresses of the counter window
    localparam logic [31:0] ADDR_CYCLE   = 32'h8000_0010;
    localparam logic [31:0] ADDR_INST    = 32'h8000_0014;
    localparam logic [31:0] ADDR_CLEAR   = 32'h8000_0018;
    localparam logic [31:0] ADDR_BRANCH  = 32'h8000_001C;
    localparam logic [31:0] ADDR_CORRECT = 32'h8000_0020;

endpackage

// File: rtl/perf_counter_mmio_if.sv
// Bus between memory-stage control (master) and the counter file (slave).
interface perf_counter_mmio_if #(
    parameter int CNT_W = 32
);
    logic             stall;
    logic             inst_retire_v;
    logic             branch_retire_v;
    logic             branch_correct_v;
    logic             io_reset;
    logic             rd_en;
    logic [1:0]       counter_sel;
    logic [CNT_W-1:0] rd_data;
    logic             rd_valid;

    modport master (
        output stall, inst_retire_v, branch_retire_v, branch_correct_v,
        output io_reset, rd_en, counter_sel,
        input  rd_data, rd_valid
    );

    modport slave (
        input  stall, inst_retire_v, branch_retire_v, branch_correct_v,
        input  io_reset, rd_en, counter_sel,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/perf_counter_mmio_counter.sv
// Single event counter: synchronous clear has priority over increment;
// at all-ones it either wraps to zero or sticks, depending on WRAP.
module perf_counter #(
    parameter int CNT_W = 32,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] value
);
    localparam logic [CNT_W-1:0] ALL_ONES = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear beats increment; saturating mode holds at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (inc) begin
            if (!WRAP && (cnt_q == ALL_ONES)) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value = cnt_q;
endmodule

// File: rtl/perf_counter_mmio.sv
// Performance-counter file behind the IO load/store window. Qualifies the
// retire events with stall, keeps four counters and returns the selected one
// one cycle after a load so it lines up with synchronous DMEM read data.
module perf_counter_mmio
    import perf_counter_mmio_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter bit WRAP  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    perf_counter_mmio_if.slave    bus
);
    logic [NUM_CNT-1:0] inc_s;
    logic [CNT_W-1:0]   cnt_val_s [NUM_CNT];
    logic [CNT_W-1:0]   sel_val_s;
    logic [CNT_W-1:0]   rd_data_q;
    logic [CNT_W-1:0]   rd_data_d;
    logic               rd_valid_q;
    logic               rd_valid_d;

    // Increment qualification: cycles always count, retire events only when not frozen
    always_comb begin
        inc_s               = {NUM_CNT{1'b0}};
        inc_s[CSEL_CYCLE]   = 1'b1;
        inc_s[CSEL_INST]    = bus.inst_retire_v & ~bus.stall;
        inc_s[CSEL_BRANCH]  = bus.branch_retire_v & ~bus.stall;
        inc_s[CSEL_CORRECT] = bus.branch_retire_v & bus.branch_correct_v & ~bus.stall;
    end

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        perf_counter #(
            .CNT_W (CNT_W),
            .WRAP  (WRAP)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (inc_s[i]),
            .clr   (bus.io_reset),
            .value (cnt_val_s[i])
        );
    end

    // 4:1 read mux over the pre-update counter values
    always_comb begin
        sel_val_s = {CNT_W{1'b0}};
        case (bus.counter_sel)
            CSEL_CYCLE:   sel_val_s = cnt_val_s[CSEL_CYCLE];
            CSEL_INST:    sel_val_s = cnt_val_s[CSEL_INST];
            CSEL_BRANCH:  sel_val_s = cnt_val_s[CSEL_BRANCH];
            CSEL_CORRECT: sel_val_s = cnt_val_s[CSEL_CORRECT];
            default:      sel_val_s = {CNT_W{1'b0}};
        endcase
    end

    // Read capture: only an unstalled load refreshes rd_data; otherwise it holds
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (bus.rd_en && !bus.stall) begin
            rd_data_d  = sel_val_s;
            rd_valid_d = 1'b1;
        end else begin
            rd_data_d  = rd_data_q;
            rd_valid_d = 1'b0;
        end
    end

    // Read-data output registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= {CNT_W{1'b0}};
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_perf_counter_mmio.sv
// Bench for perf_counter_mmio: a 32-bit wrapping instance plus 8-bit wrapping
// and 8-bit saturating instances, all driven by the same stimulus. Reference
// counts are unbounded event totals since the last clear, folded to each
// instance's width/mode when a read is expected.
module tb_perf_counter_mmio;
    import perf_counter_mmio_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       stall;
    logic       inst_retire_v;
    logic       branch_retire_v;
    logic       branch_correct_v;
    logic       io_reset;
    logic       rd_en;
    logic [1:0] counter_sel;

    int vectors     = 0;
    int miscompares = 0;
    string phase    = "init";

    perf_counter_mmio_if #(.CNT_W(32)) if32 ();
    perf_counter_mmio_if #(.CNT_W(8))  if8w ();
    perf_counter_mmio_if #(.CNT_W(8))  if8s ();

    assign if32.stall = stall;            assign if8w.stall = stall;            assign if8s.stall = stall;
    assign if32.inst_retire_v = inst_retire_v;       assign if8w.inst_retire_v = inst_retire_v;       assign if8s.inst_retire_v = inst_retire_v;
    assign if32.branch_retire_v = branch_retire_v;   assign if8w.branch_retire_v = branch_retire_v;   assign if8s.branch_retire_v = branch_retire_v;
    assign if32.branch_correct_v = branch_correct_v; assign if8w.branch_correct_v = branch_correct_v; assign if8s.branch_correct_v = branch_correct_v;
    assign if32.io_reset = io_reset;      assign if8w.io_reset = io_reset;      assign if8s.io_reset = io_reset;
    assign if32.rd_en = rd_en;            assign if8w.rd_en = rd_en;            assign if8s.rd_en = rd_en;
    assign if32.counter_sel = counter_sel; assign if8w.counter_sel = counter_sel; assign if8s.counter_sel = counter_sel;

    perf_counter_mmio #(.CNT_W(32), .WRAP(1'b1)) dut32  (.clk(clk), .rst_n(rst_n), .bus(if32));
    perf_counter_mmio #(.CNT_W(8),  .WRAP(1'b1)) dut8w  (.clk(clk), .rst_n(rst_n), .bus(if8w));
    perf_counter_mmio #(.CNT_W(8),  .WRAP(1'b0)) dut8s  (.clk(clk), .rst_n(rst_n), .bus(if8s));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: event totals since last clear/reset (0 cyc,1 inst,2 br,3 ok)
    longint unsigned raw [4];
    longint unsigned exp_rd32, exp_rd8w, exp_rd8s;
    logic            exp_vld;

    function automatic longint unsigned fold32(input longint unsigned v);
        return v % 64'd4294967296;
    endfunction
    function automatic longint unsigned fold8w(input longint unsigned v);
        return v % 64'd256;
    endfunction
    function automatic longint unsigned fold8s(input longint unsigned v);
        return (v > 64'd255) ? 64'd255 : v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s/%s: observed %0d expected %0d", phase, tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("rd_valid32", {63'd0, if32.rd_valid}, {63'd0, exp_vld});
        chk("rd_valid8w", {63'd0, if8w.rd_valid}, {63'd0, exp_vld});
        chk("rd_valid8s", {63'd0, if8s.rd_valid}, {63'd0, exp_vld});
        chk("rd_data32",  {32'd0, if32.rd_data},  exp_rd32);
        chk("rd_data8w",  {56'd0, if8w.rd_data},  exp_rd8w);
        chk("rd_data8s",  {56'd0, if8s.rd_data},  exp_rd8s);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) raw[i] = 64'd0;
    endtask

    // One clock: apply inputs, take the edge, advance the model, check outputs
    task automatic step(input logic ir, input logic bv, input logic okv, input logic clr,
                        input logic rd, input logic [1:0] sel, input logic st);
        stall = st; inst_retire_v = ir; branch_retire_v = bv; branch_correct_v = okv;
        io_reset = clr; rd_en = rd; counter_sel = sel;
        @(posedge clk);
        if (rd && !st) begin
            exp_rd32 = fold32(raw[sel]);
            exp_rd8w = fold8w(raw[sel]);
            exp_rd8s = fold8s(raw[sel]);
            exp_vld  = 1'b1;
        end else begin
            exp_vld  = 1'b0;
        end
        if (clr) begin
            model_clear();
        end else begin
            raw[0] += 64'd1;
            if (ir && !st)        raw[1] += 64'd1;
            if (bv && !st)        raw[2] += 64'd1;
            if (bv && okv && !st) raw[3] += 64'd1;
        end
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic rd(input logic [1:0] sel);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, sel, 1'b0);
    endtask

    initial begin
        stall = 1'b0; inst_retire_v = 1'b0; branch_retire_v = 1'b0; branch_correct_v = 1'b0;
        io_reset = 1'b0; rd_en = 1'b0; counter_sel = 2'd0;
        model_clear();
        exp_rd32 = 64'd0; exp_rd8w = 64'd0; exp_rd8s = 64'd0; exp_vld = 1'b0;

        // Reset state
        phase = "reset";
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_outputs();
        #1 rst_n = 1'b1;

        // 1: idle 10 edges, then read cycle counter
        phase = "t1";
        idle(10);
        rd(CSEL_CYCLE);
        chk("cycle_is_10", {32'd0, if32.rd_data}, 64'd10);
        idle(1);
        chk("valid_one_cycle", {63'd0, if32.rd_valid}, 64'd0);

        // 2: 5 retires, 3 branches, 2 correct, one stray correct without a branch
        phase = "t2";
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        rd(CSEL_INST);    chk("inst_5", {32'd0, if32.rd_data}, 64'd5);
        rd(CSEL_BRANCH);  chk("br_3",   {32'd0, if32.rd_data}, 64'd3);
        rd(CSEL_CORRECT); chk("ok_2",   {32'd0, if32.rd_data}, 64'd2);

        // 3: four stalled cycles with retire and rd_en asserted
        phase = "t3";
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, CSEL_INST, 1'b1);
        chk("stall_hold", {32'd0, if32.rd_data}, 64'd2);
        rd(CSEL_INST);    chk("inst_still_5", {32'd0, if32.rd_data}, 64'd5);
        rd(CSEL_CYCLE);

        // 4: clear together with retire and a read of inst=7
        phase = "t4";
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, CSEL_INST, 1'b0);
        chk("pre_clear_7", {32'd0, if32.rd_data}, 64'd7);
        rd(CSEL_INST);  chk("post_clear_0",  {32'd0, if32.rd_data}, 64'd0);
        rd(CSEL_CYCLE); chk("cycle_restart", {32'd0, if32.rd_data}, 64'd1);

        // 5: 256 retires on the 8-bit instances, wrap vs saturate
        phase = "t5";
        for (int i = 0; i < 256; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        rd(CSEL_INST);
        chk("wrap_0",   {56'd0, if8w.rd_data}, 64'd0);
        chk("sat_255",  {56'd0, if8s.rd_data}, 64'd255);
        chk("w32_256",  {32'd0, if32.rd_data}, 64'd256);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        rd(CSEL_INST);
        chk("sat_hold", {56'd0, if8s.rd_data}, 64'd255);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
        rd(CSEL_INST);
        chk("sat_clear", {56'd0, if8s.rd_data}, 64'd0);

        // Randomized traffic against the model
        phase = "rand";
        for (int i = 0; i < 400; i++) begin
            logic ir, bv, okv, clr, r, st;
            logic [1:0] sel;
            ir  = 1'($urandom_range(0, 1));
            bv  = ir & 1'($urandom_range(0, 1));
            okv = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 49) == 0);
            r   = 1'($urandom_range(0, 1));
            st  = ($urandom_range(0, 3) == 0);
            sel = 2'($urandom_range(0, 3));
            step(ir, bv, okv, clr, r, sel, st);
        end

        // 6: asynchronous reset mid-count at cycle=1234
        phase = "t6";
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 2000 && raw[0] < 64'd1234; i++) idle(1);
        rd(CSEL_CYCLE);
        chk("cycle_1234", {32'd0, if32.rd_data}, 64'd1234);
        #2 rst_n = 1'b0;
        model_clear();
        exp_rd32 = 64'd0; exp_rd8w = 64'd0; exp_rd8s = 64'd0; exp_vld = 1'b0;
        #1 check_outputs();
        #2 rst_n = 1'b1;
        idle(3);
        rd(CSEL_CYCLE);
        chk("resume_3", {32'd0, if32.rd_data}, 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
